// File: rtl/sr_load_sched_pkg.sv
// Shared encodings and default sizes for the shift-register load scheduler.
package sr_load_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SHIFT  = 2'b01,
        ST_STROBE = 2'b10,
        ST_GAP    = 2'b11
    } state_e;

    localparam logic SEL_DYN  = 1'b1;
    localparam logic SEL_STAT = 1'b0;

    localparam int SIZESRSTAT_DEF = 88;
    localparam int SIZESRDYN_DEF  = 16;
    localparam int GAP_CYCLES_DEF = 30;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_serializer.sv
// Left-justified shadow register that shifts one bit per cycle, MSB first,
// with a down-counter flagging the final bit.
module sr_serializer #(
    parameter int W  = 88,
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic [CW-1:0] load_cnt,
    input  logic          shift,
    output logic          done,
    output logic          mosi,
    output logic          sclk_en
);

    logic [W-1:0]  shadow_q, shadow_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic          mosi_q, mosi_d;
    logic          sclk_en_q, sclk_en_d;

    always_comb begin
        shadow_d  = shadow_q;
        bitcnt_d  = bitcnt_q;
        mosi_d    = 1'b0;
        sclk_en_d = 1'b0;
        if (load) begin
            shadow_d = load_data;
            bitcnt_d = load_cnt;
        end else if (shift) begin
            mosi_d    = shadow_q[W-1];
            sclk_en_d = 1'b1;
            shadow_d  = shadow_q << 1;
            // Counter parks at zero so it never wraps.
            if (bitcnt_q != '0) begin
                bitcnt_d = bitcnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            bitcnt_q  <= '0;
            mosi_q    <= 1'b0;
            sclk_en_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            bitcnt_q  <= bitcnt_d;
            mosi_q    <= mosi_d;
            sclk_en_q <= sclk_en_d;
        end
    end

    assign done    = (bitcnt_q == '0);
    assign mosi    = mosi_q;
    assign sclk_en = sclk_en_q;

endmodule

// File: rtl/sr_load_sched.sv
// Round-robin scheduler sharing one serial shift-register port between the
// dynamic and static register updaters, with latch strobe and frame gap.
module sr_load_sched
    import sr_load_sched_pkg::*;
#(
    parameter int SIZESRSTAT = SIZESRSTAT_DEF,
    parameter int SIZESRDYN  = SIZESRDYN_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  DYN_REQ,
    input  logic [SIZESRDYN-1:0]  DYN_DATA,
    output logic                  DYN_ACK,
    input  logic                  STAT_REQ,
    input  logic [SIZESRSTAT-1:0] STAT_DATA,
    output logic                  STAT_ACK,
    output logic                  SEL,
    output logic                  MOSI,
    output logic                  SCLK_EN,
    output logic                  LATCH,
    output logic                  BUSY
);

    localparam int W  = max_int(SIZESRSTAT, SIZESRDYN);
    localparam int CW = $clog2(W);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e        state_q, state_d;
    logic          last_src_q, last_src_d;
    logic [GW-1:0] gapcnt_q, gapcnt_d;
    logic          dyn_ack_q, dyn_ack_d;
    logic          stat_ack_q, stat_ack_d;
    logic          sel_q, sel_d;
    logic          latch_q, latch_d;
    logic          busy_q, busy_d;

    logic          pick_dyn, pick_stat;
    logic [W-1:0]  dyn_ext, stat_ext;
    logic          ser_load, ser_shift, ser_done;
    logic [W-1:0]  ser_data;
    logic [CW-1:0] ser_cnt;

    always_comb begin
        dyn_ext  = '0;
        stat_ext = '0;
        dyn_ext[W-1 -: SIZESRDYN]   = DYN_DATA;
        stat_ext[W-1 -: SIZESRSTAT] = STAT_DATA;
    end

    // On contention the source that did not win last time goes first.
    assign pick_dyn  = DYN_REQ && (!STAT_REQ || last_src_q == SEL_STAT);
    assign pick_stat = STAT_REQ && !pick_dyn;

    always_comb begin
        state_d    = state_q;
        last_src_d = last_src_q;
        gapcnt_d   = gapcnt_q;
        dyn_ack_d  = 1'b0;
        stat_ack_d = 1'b0;
        sel_d      = sel_q;
        latch_d    = 1'b0;
        busy_d     = busy_q;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        ser_data   = dyn_ext;
        ser_cnt    = CW'(SIZESRDYN - 1);
        unique case (state_q)
            ST_IDLE: begin
                if (pick_dyn) begin
                    dyn_ack_d  = 1'b1;
                    ser_load   = 1'b1;
                    sel_d      = SEL_DYN;
                    last_src_d = SEL_DYN;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end else if (pick_stat) begin
                    stat_ack_d = 1'b1;
                    ser_load   = 1'b1;
                    ser_data   = stat_ext;
                    ser_cnt    = CW'(SIZESRSTAT - 1);
                    sel_d      = SEL_STAT;
                    last_src_d = SEL_STAT;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_shift = 1'b1;
                if (ser_done) begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                latch_d  = 1'b1;
                gapcnt_d = '0;
                if (GAP_CYCLES > 0) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_GAP: begin
                if (gapcnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gapcnt_d = gapcnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            last_src_q <= SEL_STAT;
            gapcnt_q   <= '0;
            dyn_ack_q  <= 1'b0;
            stat_ack_q <= 1'b0;
            sel_q      <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            gapcnt_q   <= gapcnt_d;
            dyn_ack_q  <= dyn_ack_d;
            stat_ack_q <= stat_ack_d;
            sel_q      <= sel_d;
            latch_q    <= latch_d;
            busy_q     <= busy_d;
        end
    end

    sr_serializer #(
        .W  (W),
        .CW (CW)
    ) u_ser (
        .clk       (CLK),
        .rst_n     (RST_N),
        .load      (ser_load),
        .load_data (ser_data),
        .load_cnt  (ser_cnt),
        .shift     (ser_shift),
        .done      (ser_done),
        .mosi      (MOSI),
        .sclk_en   (SCLK_EN)
    );

    assign DYN_ACK  = dyn_ack_q;
    assign STAT_ACK = stat_ack_q;
    assign SEL      = sel_q;
    assign LATCH    = latch_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_sr_load_sched.sv
// Bench for sr_load_sched: frame-offset reference model plus directed
// scenarios, and a zero-gap instance exercised back to back.
module tb_sr_load_sched;

    localparam int G    = 30;
    localparam int SDYN = 16;
    localparam int SST  = 88;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic           DYN_REQ = 1'b0, STAT_REQ = 1'b0;
    logic [15:0]    DYN_DATA = '0;
    logic [87:0]    STAT_DATA = '0;
    logic           DYN_ACK, STAT_ACK, SEL, MOSI, SCLK_EN, LATCH, BUSY;

    logic           D0_REQ = 1'b0, S0_REQ = 1'b0;
    logic [15:0]    D0_DATA = '0;
    logic [87:0]    S0_DATA = '0;
    logic           D0_ACK, S0_ACK, SEL0, MOSI0, SCLK_EN0, LATCH0, BUSY0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    sr_load_sched #(.SIZESRSTAT(SST), .SIZESRDYN(SDYN), .GAP_CYCLES(G)) u_dut (
        .CLK(CLK), .RST_N(RST_N),
        .DYN_REQ(DYN_REQ), .DYN_DATA(DYN_DATA), .DYN_ACK(DYN_ACK),
        .STAT_REQ(STAT_REQ), .STAT_DATA(STAT_DATA), .STAT_ACK(STAT_ACK),
        .SEL(SEL), .MOSI(MOSI), .SCLK_EN(SCLK_EN), .LATCH(LATCH), .BUSY(BUSY)
    );

    sr_load_sched #(.SIZESRSTAT(SST), .SIZESRDYN(SDYN), .GAP_CYCLES(0)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N),
        .DYN_REQ(D0_REQ), .DYN_DATA(D0_DATA), .DYN_ACK(D0_ACK),
        .STAT_REQ(S0_REQ), .STAT_DATA(S0_DATA), .STAT_ACK(S0_ACK),
        .SEL(SEL0), .MOSI(MOSI0), .SCLK_EN(SCLK_EN0), .LATCH(LATCH0), .BUSY(BUSY0)
    );

    // Requesters drop their request once acknowledged.
    always @(negedge CLK) begin
        if (DYN_ACK)  DYN_REQ = 1'b0;
        if (STAT_ACK) STAT_REQ = 1'b0;
        if (D0_ACK)   D0_REQ = 1'b0;
        if (S0_ACK)   S0_REQ = 1'b0;
    end

    // Reference model: remembers the last grant and derives every output
    // from the cycle offset since that grant.
    int          cyc = 0, g_cyc = 0, g_size = 0;
    bit          have = 0;
    logic        g_src = 1'b0, sel_m = 1'b0, last_m = 1'b0;
    logic [87:0] g_word = '0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            have   = 0;
            sel_m  = 1'b0;
            last_m = 1'b0;
        end else begin
            cyc++;
            if (!have || cyc >= g_cyc + g_size + 2 + G) begin
                if (DYN_REQ && (!STAT_REQ || !last_m)) begin
                    have = 1; g_cyc = cyc; g_src = 1'b1; g_size = SDYN;
                    g_word = {72'd0, DYN_DATA};
                    sel_m = 1'b1; last_m = 1'b1;
                end else if (STAT_REQ) begin
                    have = 1; g_cyc = cyc; g_src = 1'b0; g_size = SST;
                    g_word = STAT_DATA;
                    sel_m = 1'b0; last_m = 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin : cmp
        int k;
        logic [6:0] e, a;
        k = cyc - g_cyc;
        e = '0;
        e[4] = sel_m;
        if (have) begin
            e[6] = (k == 0) && g_src;
            e[5] = (k == 0) && !g_src;
            if (k >= 1 && k <= g_size) begin
                e[3] = g_word[g_size - k];
                e[2] = 1'b1;
            end
            e[1] = (k == g_size + 1);
            e[0] = (k <= g_size + G);
        end
        a = {DYN_ACK, STAT_ACK, SEL, MOSI, SCLK_EN, LATCH, BUSY};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL model cyc=%0d ack_d,ack_s,sel,mosi,sclk,latch,busy act=%b exp=%b",
                     cyc, a, e);
        end
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(output int n, output logic d, output logic s);
        n = 0; d = 1'b0; s = 1'b0;
        while (n < 400 && !(d || s)) begin
            @(negedge CLK);
            n++;
            d = DYN_ACK;
            s = STAT_ACK;
        end
        chk("ack_seen", {127'd0, d | s}, 128'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (BUSY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_reached", {127'd0, BUSY}, 128'd0);
    endtask

    task automatic capture(output logic [127:0] bits, output int nsclk,
                           output int nlatch, output int latch_k,
                           output int low_k, output logic sel_hi,
                           output logic sel_lo);
        int k;
        bits = '0; nsclk = 0; nlatch = 0; latch_k = -1;
        sel_hi = 1'b0; sel_lo = 1'b0; k = 0;
        do begin
            @(negedge CLK);
            k++;
            if (SCLK_EN) begin
                bits = {bits[126:0], MOSI};
                nsclk++;
            end
            if (LATCH) begin
                nlatch++;
                latch_k = k;
            end
            if (SEL) sel_hi = 1'b1;
            else     sel_lo = 1'b1;
        end while (BUSY && k < 300);
        low_k = k;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    localparam logic [87:0] W1 = 88'h123456789ABCDEF1234567;
    localparam logic [87:0] W2 = 88'hFEDCBA9876543210A5C3E1;

    initial begin
        logic [127:0] bits;
        int nsclk, nlatch, latch_k, low_k, n, acks;
        logic sel_hi, sel_lo, d, s;
        int kd, ks, l1, l2, ns0;
        logic sclk_at_ks;
        logic [15:0] b0;

        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {121'd0, DYN_ACK, STAT_ACK, SEL, MOSI, SCLK_EN, LATCH, BUSY}, 128'd0);
        @(posedge CLK); #2 RST_N = 1'b1;

        // Dynamic only; data changes after ACK must not matter.
        @(negedge CLK);
        DYN_DATA = 16'hABCD; DYN_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("dyn_only_src", {126'd0, d, s}, 128'd2);
        DYN_DATA = 16'h0000;
        capture(bits, nsclk, nlatch, latch_k, low_k, sel_hi, sel_lo);
        chk("dyn_bits", bits, 128'hABCD);
        chk("dyn_nsclk", nsclk, 16);
        chk("dyn_nlatch", nlatch, 1);
        chk("dyn_latch_k", latch_k, 17);
        chk("dyn_busy_low_k", low_k, 47);
        chk("dyn_sel_stable", {126'd0, sel_hi, sel_lo}, 128'd2);

        // Static only.
        STAT_DATA = W1; STAT_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("stat_only_src", {126'd0, d, s}, 128'd1);
        capture(bits, nsclk, nlatch, latch_k, low_k, sel_hi, sel_lo);
        chk("stat_bits", bits, {40'd0, W1});
        chk("stat_nsclk", nsclk, 88);
        chk("stat_nlatch", nlatch, 1);
        chk("stat_latch_k", latch_k, 89);
        chk("stat_sel_stable", {126'd0, sel_hi, sel_lo}, 128'd1);

        // Simultaneous requests: dynamic first, static GAP+1 after LATCH.
        DYN_DATA = 16'h1234; STAT_DATA = W2;
        DYN_REQ = 1'b1; STAT_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("both_first_dyn", {126'd0, d, s}, 128'd2);
        capture(bits, nsclk, nlatch, latch_k, low_k, sel_hi, sel_lo);
        chk("both_dyn_bits", bits, 128'h1234);
        wait_ack(n, d, s);
        chk("both_second_stat", {126'd0, d, s}, 128'd1);
        chk("both_stat_after_latch", n + low_k - latch_k, G + 1);
        @(negedge CLK);
        DYN_DATA = 16'h0F0F; DYN_REQ = 1'b1; STAT_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("third_dyn_wins", {126'd0, d, s}, 128'd2);
        wait_ack(n, d, s);
        chk("repeat_stat_next", {126'd0, d, s}, 128'd1);
        wait_idle();

        // Static request raised while a dynamic frame is shifting.
        @(negedge CLK);
        DYN_DATA = 16'h5A5A; DYN_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("busy_dyn_src", {126'd0, d, s}, 128'd2);
        repeat (5) @(negedge CLK);
        STAT_DATA = W1; STAT_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("busy_stat_src", {126'd0, d, s}, 128'd1);
        chk("busy_stat_wait", n, 43);

        // A request dropped before it could be granted produces nothing.
        repeat (2) @(negedge CLK);
        DYN_REQ = 1'b1;
        repeat (3) @(negedge CLK);
        DYN_REQ = 1'b0;
        wait_idle();
        acks = 0;
        repeat (5) begin
            @(negedge CLK);
            acks += int'(DYN_ACK) + int'(STAT_ACK);
        end
        chk("dropped_req_no_ack", acks, 0);

        // Reset at bit 40 of a static frame.
        STAT_DATA = W2; STAT_REQ = 1'b1;
        wait_ack(n, d, s);
        chk("rst_stat_src", {126'd0, d, s}, 128'd1);
        repeat (40) @(negedge CLK);
        chk("rst_bit40_sclk", {127'd0, SCLK_EN}, 128'd1);
        DYN_DATA = 16'h8001; DYN_REQ = 1'b1;
        @(posedge CLK); #2 RST_N = 1'b0;
        #1;
        chk("async_reset_zero", {121'd0, DYN_ACK, STAT_ACK, SEL, MOSI, SCLK_EN, LATCH, BUSY}, 128'd0);
        acks = 0;
        repeat (3) begin
            @(negedge CLK);
            acks += int'(LATCH);
        end
        chk("reset_no_latch", acks, 0);
        @(posedge CLK); #2 RST_N = 1'b1;
        wait_ack(n, d, s);
        chk("post_rst_dyn_first", {126'd0, d, s}, 128'd2);
        chk("post_rst_ack_wait", n, 2);
        wait_idle();

        // Zero-gap instance: back-to-back frames.
        @(negedge CLK);
        D0_DATA = 16'hC3A5; S0_DATA = W1;
        D0_REQ = 1'b1; S0_REQ = 1'b1;
        kd = -1; ks = -1; l1 = -1; l2 = -1; ns0 = 0; b0 = '0;
        sclk_at_ks = 1'b1;
        for (int k = 1; k <= 115; k++) begin
            @(negedge CLK);
            if (D0_ACK) kd = k;
            if (S0_ACK) begin
                ks = k;
                sclk_at_ks = SCLK_EN0;
            end
            if (LATCH0) begin
                if (l1 < 0) l1 = k;
                else        l2 = k;
            end
            if (SCLK_EN0) begin
                ns0++;
                if (ns0 <= 16) b0 = {b0[14:0], MOSI0};
            end
        end
        chk("g0_dyn_ack_k", kd, 1);
        chk("g0_latch1_k", l1, 18);
        chk("g0_stat_ack_k", ks, 19);
        chk("g0_no_sclk_at_ack", {127'd0, sclk_at_ks}, 128'd0);
        chk("g0_latch2_k", l2, 108);
        chk("g0_nsclk", ns0, 104);
        chk("g0_dyn_bits", {112'd0, b0}, 128'hC3A5);
        chk("g0_busy_low", {127'd0, BUSY0}, 128'd0);

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
